// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter owner with IDLE/RUN/HALTED sequencing
// Optional branch/cycle statistics counters enabled by PC_BRANCH_STATS_EN.
module pc_sequencer #(
  parameter int unsigned    D          = 12,
  parameter logic [D-1:0]   PROG0_ADDR = '0,
  parameter logic [D-1:0]   PROG1_ADDR = 12'h100,
  parameter logic [D-1:0]   PROG2_ADDR = 12'h200
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic [1:0]   prog_sel,
  input  logic         branch_en,
  input  logic         taken,
  input  logic [D-1:0] target,
  input  logic         halt,
  output logic [D-1:0] prog_ctr,
  output logic         running,
  output logic         Done
`ifdef PC_BRANCH_STATS_EN
  ,
  output logic [15:0]  branch_count,
  output logic [15:0]  cycle_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t       r_state;
  logic [D-1:0] r_pc;
  logic         r_running;
  logic         r_done;
  logic [D-1:0] w_start_addr;
  logic         w_take;

  always_comb begin
    w_start_addr = PROG0_ADDR;
    case (prog_sel)
      2'd0:    w_start_addr = PROG0_ADDR;
      2'd1:    w_start_addr = PROG1_ADDR;
      default: w_start_addr = PROG2_ADDR;
    endcase
  end

  // Halt has priority, so a branch only counts as taken when halt is low.
  assign w_take = !halt && branch_en && taken;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (halt) begin
            r_state   <= S_HALTED;
            r_running <= 1'b0;
            r_done    <= 1'b1;
          end else if (w_take) begin
            r_pc <= r_pc + target;
          end else begin
            r_pc <= r_pc + 1'b1;
          end
        end
        default: begin
          if (Start) begin
            r_state   <= S_RUN;
            r_pc      <= w_start_addr;
            r_running <= 1'b1;
            r_done    <= 1'b0;
          end
        end
      endcase
    end
  end

  assign prog_ctr = r_pc;
  assign running  = r_running;
  assign Done     = r_done;

`ifdef PC_BRANCH_STATS_EN
  logic [15:0] r_branch_count;
  logic [15:0] r_cycle_count;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_branch_count <= '0;
      r_cycle_count  <= '0;
    end else if (r_state != S_RUN) begin
      if (Start) begin
        r_branch_count <= '0;
        r_cycle_count  <= '0;
      end
    end else begin
      if (r_cycle_count != 16'hFFFF)
        r_cycle_count <= r_cycle_count + 16'd1;
      if (w_take && r_branch_count != 16'hFFFF)
        r_branch_count <= r_branch_count + 16'd1;
    end
  end

  assign branch_count = r_branch_count;
  assign cycle_count  = r_cycle_count;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer
// Stats ports are exercised when PC_BRANCH_STATS_EN is defined.
module tb_pc_sequencer;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic [1:0]  prog_sel;
  logic        branch_en;
  logic        taken;
  logic [11:0] target;
  logic        halt;
  logic [11:0] prog_ctr;
  logic        running;
  logic        Done;
`ifdef PC_BRANCH_STATS_EN
  logic [15:0] branch_count;
  logic [15:0] cycle_count;
`endif

  pc_sequencer dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .prog_sel  (prog_sel),
    .branch_en (branch_en),
    .taken     (taken),
    .target    (target),
    .halt      (halt),
    .prog_ctr  (prog_ctr),
    .running   (running),
    .Done      (Done)
`ifdef PC_BRANCH_STATS_EN
    ,
    .branch_count (branch_count),
    .cycle_count  (cycle_count)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [11:0] pc;
    logic        run;
    logic        done;
    logic [15:0] bc;
    logic [15:0] cc;
  } exp_t;

  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  // reference model state: 0 idle, 1 run, 2 halted
  int          m_st = 0;
  logic [11:0] m_pc = '0;
  logic [15:0] m_bc = '0;
  logic [15:0] m_cc = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] start_addr(input logic [1:0] sel);
    case (sel)
      2'd0:    return 12'h000;
      2'd1:    return 12'h100;
      default: return 12'h200;
    endcase
  endfunction

  task automatic model_step(input logic rst, input logic st, input logic [1:0] sel,
                            input logic be, input logic tk, input logic [11:0] tg,
                            input logic hl);
    exp_t e;
    if (rst) begin
      m_st = 0; m_pc = '0; m_bc = '0; m_cc = '0;
    end else if (m_st == 1) begin
      if (m_cc != 16'hFFFF) m_cc = m_cc + 16'd1;
      if (hl) m_st = 2;
      else if (be && tk) begin
        m_pc = m_pc + tg;
        if (m_bc != 16'hFFFF) m_bc = m_bc + 16'd1;
      end else m_pc = m_pc + 12'd1;
    end else if (st) begin
      m_st = 1; m_pc = start_addr(sel); m_bc = '0; m_cc = '0;
    end
    e.pc = m_pc; e.run = (m_st == 1); e.done = (m_st == 2); e.bc = m_bc; e.cc = m_cc;
    sb.push_back(e);
  endtask

  task automatic cyc(input string tag, input logic rst, input logic st, input logic [1:0] sel,
                     input logic be, input logic tk, input logic [11:0] tg, input logic hl);
    exp_t e;
    Reset = rst; Start = st; prog_sel = sel; branch_en = be; taken = tk; target = tg; halt = hl;
    model_step(rst, st, sel, be, tk, tg, hl);
    @(posedge Clk);
    #1;
    e = sb.pop_front();
    check_eq({tag, ".pc"}, 32'(prog_ctr), 32'(e.pc));
    check_eq({tag, ".run"}, 32'(running), 32'(e.run));
    check_eq({tag, ".done"}, 32'(Done), 32'(e.done));
`ifdef PC_BRANCH_STATS_EN
    check_eq({tag, ".bc"}, 32'(branch_count), 32'(e.bc));
    check_eq({tag, ".cc"}, 32'(cycle_count), 32'(e.cc));
`endif
  endtask

  task automatic inc(input string tag);
    cyc(tag, 0, 0, 2'd0, 0, 0, 12'h000, 0);
  endtask

  task automatic br(input string tag, input logic tk, input logic [11:0] tg);
    cyc(tag, 0, 0, 2'd0, 1, tk, tg, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset = 1; Start = 0; prog_sel = 0; branch_en = 0; taken = 0; target = 0; halt = 0;
    cyc("reset", 1, 0, 2'd0, 0, 0, 12'h000, 0);
    check_eq("reset_pc_const", 32'(prog_ctr), 32'h0);
    inc("idle_hold");

    cyc("start1", 0, 1, 2'd1, 0, 0, 12'h000, 0);
    check_eq("start1_pc_const", 32'(prog_ctr), 32'h100);
    for (int i = 0; i < 5; i++) inc("run_inc");
    check_eq("pc_105_const", 32'(prog_ctr), 32'h105);
    cyc("reset_mid", 1, 0, 2'd0, 1, 1, 12'h010, 0);
    inc("post_reset_idle");

    cyc("start2", 0, 1, 2'd2, 0, 0, 12'h000, 0);
    br("back_br", 1, 12'hF97);
    check_eq("back_br_const", 32'(prog_ctr), 32'h197);
    br("not_taken", 0, 12'h123);
    check_eq("not_taken_const", 32'(prog_ctr), 32'h198);
    br("to_fff", 1, 12'hE67);
    inc("wrap_up");
    check_eq("wrap_up_const", 32'(prog_ctr), 32'h000);
    for (int i = 0; i < 5; i++) inc("to_5");
    br("wrap_down", 1, 12'hFF6);
    check_eq("wrap_down_const", 32'(prog_ctr), 32'hFFB);
    cyc("start_in_run", 0, 1, 2'd1, 0, 0, 12'h000, 0);
    br("self_loop", 1, 12'h000);
    br("to_050", 1, 12'h054);
    check_eq("pc_050_const", 32'(prog_ctr), 32'h050);
    cyc("halt_br", 0, 0, 2'd0, 1, 1, 12'h00D, 1);
    check_eq("halt_done_const", 32'(Done), 32'h1);
    cyc("halted_hold", 0, 0, 2'd0, 1, 1, 12'h00D, 1);
    cyc("restart0", 0, 1, 2'd0, 0, 0, 12'h000, 0);
    check_eq("restart0_done_const", 32'(Done), 32'h0);

`ifdef PC_BRANCH_STATS_EN
    cyc("st_reset", 1, 0, 2'd0, 0, 0, 12'h000, 0);
    cyc("st_start", 0, 1, 2'd1, 0, 0, 12'h000, 0);
    br("st_b1", 1, 12'h004);
    inc("st_i1");
    br("st_b2", 1, 12'h000);
    br("st_nt", 0, 12'h007);
    inc("st_i2");
    br("st_b3", 1, 12'hFFE);
    inc("st_i3");
    br("st_b4", 1, 12'h002);
    inc("st_i4");
    cyc("st_halt", 0, 0, 2'd0, 1, 1, 12'h003, 1);
    check_eq("st_bc_const", 32'(branch_count), 32'd4);
    check_eq("st_cc_const", 32'(cycle_count), 32'd10);
    cyc("st_frozen", 0, 0, 2'd0, 1, 1, 12'h003, 0);
    cyc("st_restart", 0, 1, 2'd2, 0, 0, 12'h000, 0);
    check_eq("st_clear_const", 32'(cycle_count) + 32'(branch_count), 32'd0);
`endif

    for (int i = 0; i < 200; i++) begin
      cyc("rand",
          ($urandom_range(0, 39) == 0),
          ($urandom_range(0, 3) == 0),
          2'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)),
          12'($urandom),
          ($urandom_range(0, 9) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
